// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: read-mode encoding and count sizing.
package fifo_pkg;

    typedef enum logic {
        REG_READ = 1'b0,
        FWFT     = 1'b1
    } fifo_rd_mode_e;

    // Occupancy runs 0..depth inclusive, so one more code than a pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_mem_sdp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered or fall-through read, occupancy flags,
// flush and sticky error flags. Storage lives in fifo_mem_sdp.
module sync_fifo_param #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 1024,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    import fifo_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam fifo_rd_mode_e RD_MODE = (FWFT != 0) ? fifo_pkg::FWFT : REG_READ;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_af_chk
        $error("sync_fifo_param: AFULL_THRESH out of range");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_ae_chk
        $error("sync_fifo_param: AEMPTY_THRESH out of range");
    end

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mem_rd_data, rd_data_q;
    logic             rd_valid_q;
    logic             rd_acc, wr_acc, mem_we;

    // Handshake: a read is taken only when the FIFO holds data; a write is
    // taken when there is room, or when full but paired with a taken read.
    // Both decisions use registered state only, so no same-cycle pass-through.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);
    assign mem_we = wr_acc & ~flush & ~reset;

    fifo_mem_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            cnt_q <= cnt_q + CW'(wr_acc) - CW'(rd_acc);
            if (rd_acc) rd_data_q <= mem_rd_data;
            rd_valid_q <= rd_acc;
            // A new error in the same cycle as clr_err keeps the flag set.
            if (wr_en & ~wr_acc) overflow <= 1'b1;
            else if (clr_err)    overflow <= 1'b0;
            if (rd_en & empty)   underflow <= 1'b1;
            else if (clr_err)    underflow <= 1'b0;
        end
    end

    assign count        = cnt_q;
    assign full         = (cnt_q == DEPTH_C);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= AF_C);
    assign almost_empty = (cnt_q <= AE_C);

    assign rd_data  = (RD_MODE == fifo_pkg::FWFT) ? (empty ? '0 : mem_rd_data) : rd_data_q;
    assign rd_valid = (RD_MODE == fifo_pkg::FWFT) ? ~empty : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a registered-read and a fall-through instance share one
// stimulus stream; every step checks against hand-computed values.
module tb_sync_fifo_param;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic        clr_err;

    logic [15:0] r_rd_data, f_rd_data;
    logic        r_rd_valid, f_rd_valid;
    logic        r_full, f_full, r_empty, f_empty;
    logic        r_afull, f_afull, r_aempty, f_aempty;
    logic [3:0]  r_count, f_count;
    logic        r_ovf, f_ovf, r_unf, f_unf;

    int n_assert = 0;
    int n_fail   = 0;

    sync_fifo_param #(
        .WIDTH(16), .DEPTH(8), .FWFT(0), .AFULL_THRESH(6), .AEMPTY_THRESH(1)
    ) u_reg (
        .clock(clock), .reset(reset), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(r_rd_data), .rd_valid(r_rd_valid),
        .full(r_full), .empty(r_empty),
        .almost_full(r_afull), .almost_empty(r_aempty),
        .count(r_count), .overflow(r_ovf), .underflow(r_unf),
        .clr_err(clr_err)
    );

    sync_fifo_param #(
        .WIDTH(16), .DEPTH(8), .FWFT(1), .AFULL_THRESH(6), .AEMPTY_THRESH(1)
    ) u_fwft (
        .clock(clock), .reset(reset), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .empty(f_empty),
        .almost_full(f_afull), .almost_empty(f_aempty),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf),
        .clr_err(clr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r,
                       input logic f, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
        @(posedge clock);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
    endtask

    logic [15:0] exp4 [8];

    initial begin
        exp4 = '{16'h0002, 16'h0003, 16'h0004, 16'h0005,
                 16'h0006, 16'h0007, 16'h0008, 16'hAAAA};
        reset = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
        rd_en = 1'b0; clr_err = 1'b0;

        // 1. reset state
        @(posedge clock); @(posedge clock); #1;
        chk("rst_count",  r_count,    0);
        chk("rst_empty",  r_empty,    1);
        chk("rst_full",   r_full,     0);
        chk("rst_aempty", r_aempty,   1);
        chk("rst_afull",  r_afull,    0);
        chk("rst_rvalid", r_rd_valid, 0);
        chk("rst_rdata",  r_rd_data,  0);
        chk("rst_ovf",    r_ovf,      0);
        chk("rst_unf",    r_unf,      0);
        chk("rst_f_valid", f_rd_valid, 0);
        chk("rst_f_data",  f_rd_data,  0);
        reset = 1'b0;

        // 2. fill, flags, overflow, clr_err
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_count",  r_count, i);
            chk("fill_afull",  r_afull, (i >= 6) ? 1 : 0);
            chk("fill_full",   r_full,  (i == 8) ? 1 : 0);
            chk("fill_aempty", r_aempty, (i <= 1) ? 1 : 0);
            chk("fill_f_head", f_rd_data, 16'h0001);
        end
        cyc(1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
        chk("ovf_set",   r_ovf,   1);
        chk("ovf_count", r_count, 8);
        chk("ovf_f_set", f_ovf,   1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr",   r_ovf,   0);
        chk("ovf_count2", r_count, 8);

        // 3. drain in order, then underflow
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
            chk("drain_valid", r_rd_valid, 1);
            chk("drain_data",  r_rd_data,  i);
            chk("drain_count", r_count,    8 - i);
            chk("drain_f_head", f_rd_data, (i < 8) ? i + 1 : 0);
        end
        chk("drain_empty", r_empty, 1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("unf_set",    r_unf,      1);
        chk("unf_valid",  r_rd_valid, 0);
        chk("unf_count",  r_count,    0);
        chk("unf_hold",   r_rd_data,  16'h0008);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("unf_clr",    r_unf,      0);

        // 4. simultaneous read/write at full with pointer wrap
        for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        chk("wrap_full", r_full, 1);
        cyc(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        chk("rw_full_count", r_count,   8);
        chk("rw_full_ovf",   r_ovf,     0);
        chk("rw_full_data",  r_rd_data, 16'h0001);
        chk("rw_full_f_head", f_rd_data, 16'h0002);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
            chk("wrap_data",  r_rd_data,  exp4[i]);
            chk("wrap_valid", r_rd_valid, 1);
        end
        chk("wrap_empty", r_empty, 1);

        // 5. simultaneous read/write on empty
        cyc(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
        chk("rw_empty_unf",   r_unf,      1);
        chk("rw_empty_count", r_count,    1);
        chk("rw_empty_valid", r_rd_valid, 0);
        chk("rw_empty_f_data",  f_rd_data,  16'h5555);
        chk("rw_empty_f_valid", f_rd_valid, 1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("rw_empty_rd",    r_rd_data,  16'h5555);
        chk("rw_empty_rdv",   r_rd_valid, 1);
        chk("rw_empty_cnt0",  r_count,    0);
        chk("rw_empty_clr",   r_unf,      0);

        // 6. flush with a concurrent write, then fall-through visibility
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", r_count, 5);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
        chk("flush_count",   r_count,    0);
        chk("flush_empty",   r_empty,    1);
        chk("flush_ovf",     r_ovf,      0);
        chk("flush_rvalid",  r_rd_valid, 0);
        chk("flush_hold",    r_rd_data,  16'h5555);
        chk("flush_f_valid", f_rd_valid, 0);
        chk("flush_f_data",  f_rd_data,  0);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("fwft_data",  f_rd_data,  16'h1234);
        chk("fwft_valid", f_rd_valid, 1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("fwft_pop_empty", f_empty,    1);
        chk("fwft_pop_valid", f_rd_valid, 0);
        chk("fwft_pop_count", f_count,    0);
        chk("fwft_pop_reg",   r_rd_data,  16'h1234);

        // 7. reset mid-transfer discards contents
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0020 + i), 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 16'h0BAD, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        chk("mid_rst_count", r_count,   0);
        chk("mid_rst_data",  r_rd_data, 0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_f_data", f_rd_data, 16'hBEEF);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_rd",  r_rd_data, 16'hBEEF);
        chk("mid_rst_cnt", r_count,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
